// File: rtl/nibble_serial_addsub_ctrl.sv
// Nibble-serial add/subtract sequencer driving one shared external 4-bit adder.
// Operands are latched on start and processed LSB nibble first, one per clock.
module nibble_serial_addsub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic [3:0]             adder_a,
  output logic [3:0]             adder_b,
  output logic                   adder_cin,
  input  logic [3:0]             adder_s,
  input  logic                   adder_cout,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   overflow,
  output logic                   zero
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_next;
  logic [W-1:0]    op_a, op_b, acc;
  logic [W-1:0]    sh_a, sh_b, new_result;
  logic            carry;
  logic [IW-1:0]   idx;
  logic            last;

  always_comb begin
    state_next = state;
    adder_a    = '0;
    adder_b    = '0;
    adder_cin  = 1'b0;
    busy       = 1'b0;
    last       = 1'b0;
    sh_a       = op_a >> {idx, 2'b00};
    sh_b       = op_b >> {idx, 2'b00};
    // acc shifts right each nibble, so after the last one it is already in place
    new_result = {adder_s, acc[W-1:4]};
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        adder_a   = sh_a[3:0];
        adder_b   = sh_b[3:0];
        adder_cin = carry;
        last      = (idx == LAST);
        if (last) state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b ^ {W{sub}};
            carry <= sub;
            idx   <= '0;
            acc   <= '0;
          end
        end
        RUN: begin
          acc   <= new_result;
          carry <= adder_cout;
          idx   <= idx + 1'b1;
          if (last) begin
            result   <= new_result;
            cout     <= adder_cout;
            overflow <= (op_a[W-1] == op_b[W-1]) && (adder_s[3] != op_a[W-1]);
            zero     <= (new_result == '0);
            done     <= 1'b1;
            idx      <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Randomized and directed bench for nibble_serial_addsub_ctrl with an arithmetic
// reference model; a 2-nibble instance covers the narrow build.
module tb_nibble_serial_addsub_ctrl;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         start = 1'b0, sub = 1'b0;
  logic [15:0]  a = '0, b = '0;
  logic [3:0]   adder_a, adder_b, adder_s;
  logic         adder_cin, adder_cout;
  logic         busy, done, cout, overflow, zero;
  logic [15:0]  result;

  logic         start2 = 1'b0, sub2 = 1'b0;
  logic [7:0]   a2 = '0, b2 = '0;
  logic [3:0]   adder_a2, adder_b2, adder_s2;
  logic         adder_cin2, adder_cout2;
  logic         busy2, done2, cout2, overflow2, zero2;
  logic [7:0]   result2;

  int n_vec = 0, n_err = 0;
  bit chk_en = 1'b0;
  logic [7:0] cin_log;
  logic [3:0] b_first;
  int cyc;

  always #5 clk = ~clk;

  // external shared ripple adders
  always_comb {adder_cout, adder_s}   = 5'(adder_a)  + 5'(adder_b)  + 5'(adder_cin);
  always_comb {adder_cout2, adder_s2} = 5'(adder_a2) + 5'(adder_b2) + 5'(adder_cin2);

  nibble_serial_addsub_ctrl #(.NIBBLES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_s(adder_s), .adder_cout(adder_cout),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .overflow(overflow), .zero(zero));

  nibble_serial_addsub_ctrl #(.NIBBLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2),
    .adder_a(adder_a2), .adder_b(adder_b2), .adder_cin(adder_cin2),
    .adder_s(adder_s2), .adder_cout(adder_cout2),
    .busy(busy2), .done(done2), .result(result2), .cout(cout2),
    .overflow(overflow2), .zero(zero2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Whole-word arithmetic reference: unsigned for result/carry, signed range for overflow.
  function automatic void model_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                                   output logic [15:0] r, output logic c, output logic v,
                                   output logic z);
    longint ux = longint'(x), uy = longint'(y);
    longint sx = longint'($signed(x)), sy = longint'($signed(y));
    longint u, sv;
    if (s) begin
      u = ux - uy; c = (ux >= uy); sv = sx - sy;
    end else begin
      u = ux + uy; c = (u >= (longint'(1) << W)); sv = sx + sy;
    end
    r = 16'(u);
    v = (sv > 32767) || (sv < -32768);
    z = (r == 16'h0000);
  endfunction

  logic        m_busy = 0, m_done = 0, m_cout = 0, m_ovf = 0, m_zero = 0, m_sub = 0;
  logic [15:0] m_res = '0, m_a = '0, m_b = '0;
  int          m_k = 0;
  logic [15:0] t_r;
  logic        t_c, t_v, t_z;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_cout <= 0; m_ovf <= 0; m_zero <= 0;
      m_res <= '0; m_k <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_a <= a; m_b <= b; m_sub <= sub; m_busy <= 1'b1; m_k <= 0;
        end
      end else if (m_k == N - 1) begin
        model_op(m_a, m_b, m_sub, t_r, t_c, t_v, t_z);
        m_busy <= 1'b0; m_done <= 1'b1;
        m_res <= t_r; m_cout <= t_c; m_ovf <= t_v; m_zero <= t_z;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      longint bx, lm, ea, eb, ec;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("result", 32'(result), 32'(m_res));
      chk("cout", 32'(cout), 32'(m_cout));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("zero", 32'(zero), 32'(m_zero));
      ea = 0; eb = 0; ec = 0;
      if (m_busy) begin
        bx = longint'(m_sub ? ~m_b : m_b);
        lm = (longint'(1) << (4 * m_k)) - 1;
        ea = (longint'(m_a) >> (4 * m_k)) & 15;
        eb = (bx >> (4 * m_k)) & 15;
        ec = (((longint'(m_a) & lm) + (bx & lm) + longint'(m_sub)) >> (4 * m_k)) & 1;
      end
      chk("adder_a", 32'(adder_a), 32'(ea));
      chk("adder_b", 32'(adder_b), 32'(eb));
      chk("adder_cin", 32'(adder_cin), 32'(ec));
    end
  end

  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb, input logic ts);
    start = 1'b1; a = ta; b = tb; sub = ts;
    @(posedge clk); #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_done(input bit second, output int c);
    c = 0;
    cin_log = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!second && i <= 8) begin
        cin_log[i-1] = adder_cin;
        if (i == 1) b_first = adder_b;
      end
      if ((second ? done2 : done) == 1'b1) begin
        c = i;
        break;
      end
    end
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_flags", {29'd0, cout, overflow, zero}, 0);
    chk("rst_adder", {23'd0, adder_a, adder_b, adder_cin}, 0);
    chk_en = 1'b1;

    // narrow build
    @(posedge clk); #1;
    start2 = 1'b1; a2 = 8'hA5; b2 = 8'h5B; sub2 = 1'b0;
    @(posedge clk); #1; start2 = 1'b0; a2 = 8'h00; b2 = 8'h00;
    wait_done(1'b1, cyc);
    chk("n2_lat", 32'(cyc), 3);
    chk("n2_res", 32'(result2), 32'h00);
    chk("n2_flags", {29'd0, cout2, overflow2, zero2}, 32'b101);
    @(posedge clk); #1;
    start2 = 1'b1; a2 = 8'h7F; b2 = 8'h01; sub2 = 1'b0;
    @(posedge clk); #1; start2 = 1'b0;
    wait_done(1'b1, cyc);
    chk("n2_lat_b", 32'(cyc), 3);
    chk("n2_res_b", 32'(result2), 32'h80);
    chk("n2_flags_b", {29'd0, cout2, overflow2, zero2}, 32'b010);

    @(posedge clk); #1;
    start_op(16'h1234, 16'h0FFF, 1'b0);
    wait_done(1'b0, cyc);
    chk("t1_lat", 32'(cyc), 5);
    chk("t1_cin_seq", 32'(cin_log[3:0]), 32'b1110);
    chk("t1_res", 32'(result), 32'h2233);
    chk("t1_flags", {29'd0, cout, overflow, zero}, 32'b000);

    @(posedge clk); #1;
    start_op(16'hFFFF, 16'h0001, 1'b0);
    wait_done(1'b0, cyc);
    chk("t2_res", 32'(result), 32'h0000);
    chk("t2_flags", {29'd0, cout, overflow, zero}, 32'b101);

    @(posedge clk); #1;
    start_op(16'h7FFF, 16'h0001, 1'b0);
    wait_done(1'b0, cyc);
    chk("t3_res", 32'(result), 32'h8000);
    chk("t3_flags", {29'd0, cout, overflow, zero}, 32'b010);

    @(posedge clk); #1;
    start_op(16'h8000, 16'h0001, 1'b1);
    wait_done(1'b0, cyc);
    chk("t4_b0", 32'(b_first), 32'hE);
    chk("t4_cin0", 32'(cin_log[0]), 1);
    chk("t4_res", 32'(result), 32'h7FFF);
    chk("t4_flags", {29'd0, cout, overflow, zero}, 32'b110);

    @(posedge clk); #1;
    start_op(16'h0003, 16'h0005, 1'b1);
    wait_done(1'b0, cyc);
    chk("t5_res", 32'(result), 32'hFFFE);
    chk("t5_flags", {29'd0, cout, overflow, zero}, 32'b000);

    // start while busy must be ignored
    @(posedge clk); #1;
    start_op(16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1;
    @(posedge clk); #1;
    a = 16'h4321;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0, cyc);
    chk("ign_lat", 32'(cyc), 2);
    chk("ign_res", 32'(result), 32'h3333);

    // back-to-back start in the done cycle
    start_op(16'h0102, 16'h0304, 1'b0);
    wait_done(1'b0, cyc);
    chk("b2b_lat", 32'(cyc), 5);
    chk("b2b_res", 32'(result), 32'h0406);

    // asynchronous reset mid-run
    @(posedge clk); #1;
    start_op(16'h5555, 16'h1111, 1'b0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_result", 32'(result), 0);
    chk("ar_flags", {28'd0, done, cout, overflow, zero}, 0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("ar_no_done", 32'(done), 0);
    end
    @(posedge clk); #1;
    start_op(16'h0001, 16'h0002, 1'b0);
    wait_done(1'b0, cyc);
    chk("ar_next_lat", 32'(cyc), 5);
    chk("ar_next_res", 32'(result), 32'h0003);

    // randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      a = pick();
      b = pick();
      sub = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
